// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: bus master fetches into a DEPTH-entry prefetch FIFO feeding IF/ID.
// Optional macro IFU_BYPASS_EN forwards a response straight to IF/ID when the FIFO is empty.
module ifu_prefetch #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ifid_ready_i,
  output logic              ifid_valid_o,
  output logic [DATA_W-1:0] ifid_ins_o,
  output logic [ADDR_W-1:0] ifid_addr_o,
  output logic              bus_req_o,
  input  logic              bus_grnt_i,
  output logic              bus_as_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_rw_o,
  input  logic [DATA_W-1:0] bus_rd_data_i,
  input  logic              bus_rdy_i,
  output logic [1:0]        fsm_state_o
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << BYTE_SH) - ADDR_W'(1));
  localparam logic [PTR_W:0]    CNT_DEPTH  = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, ACC, DROP} state_t;

  state_t              state_q, state_d;
  logic                as_done_q;
  logic [ADDR_W-1:0]   fetch_pc_q, bus_addr_q, jump_pc;
  logic [PTR_W:0]      wr_ptr_q, rd_ptr_q, count, count_after;
  logic [ADDR_W-1:0]   addr_mem [DEPTH];
  logic [DATA_W-1:0]   ins_mem  [DEPTH];
  logic                fifo_valid, resp, bypass, push, pop;

  // IF/ID handshake: a word transfers on a rising edge where ifid_valid_o & ifid_ready_i;
  // a redirect at that edge cancels the transfer and the word is discarded.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_valid = (count != '0);
  assign jump_pc    = jump_addr_i & ALIGN_MASK;
  assign resp       = (state_q == ACC) && bus_rdy_i && !jump_en_i;

`ifdef IFU_BYPASS_EN
  assign bypass = resp && !fifo_valid;
`else
  assign bypass = 1'b0;
`endif

  assign ifid_valid_o = fifo_valid | bypass;
  assign ifid_ins_o   = bypass ? bus_rd_data_i : ins_mem[rd_ptr_q[PTR_W-1:0]];
  assign ifid_addr_o  = bypass ? bus_addr_q    : addr_mem[rd_ptr_q[PTR_W-1:0]];
  assign pop          = fifo_valid && ifid_ready_i && !jump_en_i;
  assign push         = resp && !(bypass && ifid_ready_i);
  assign count_after  = count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

  assign bus_req_o   = (state_q != IDLE);
  assign bus_as_o    = (state_q == ACC) && !as_done_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_rw_o    = 1'b1;
  assign fsm_state_o = state_q;

  // Credit check: the only in-flight fetch is the one in ACC, so IDLE/REQ need count < DEPTH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (jump_en_i || count < CNT_DEPTH) state_d = REQ;
      REQ:  if (!jump_en_i && bus_grnt_i) state_d = ACC;
      ACC: begin
        if (jump_en_i)      state_d = bus_rdy_i ? REQ : DROP;
        else if (bus_rdy_i) state_d = (count_after < CNT_DEPTH) ? REQ : IDLE;
      end
      DROP: if (bus_rdy_i) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q    <= IDLE;
      as_done_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      bus_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        ins_mem[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      as_done_q <= (state_q == ACC);
      if (state_q == REQ && bus_grnt_i && !jump_en_i) bus_addr_q <= fetch_pc_q;
      if (jump_en_i) begin
        fetch_pc_q <= jump_pc;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (resp) fetch_pc_q <= fetch_pc_q + PC_STEP;
        if (push) begin
          addr_mem[wr_ptr_q[PTR_W-1:0]] <= bus_addr_q;
          ins_mem[wr_ptr_q[PTR_W-1:0]]  <= bus_rd_data_i;
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
endmodule
